// File: rtl/pe_drain_pkg.sv
// Shared definitions for the PE result drain controller: state encoding and
// the elaboration-time sizing helpers. calc_depth is also used by the result
// RAM, so the FIFO depth and the drain word count always agree.
package pe_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PAUSE,
    ST_FLUSH,
    ST_DONE
  } drain_state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Words per bank per frame.
  function automatic int unsigned calc_depth(input int unsigned n, input int unsigned wh,
                                             input int unsigned hout, input int unsigned iw);
    return ceil_div((n / wh) * hout, iw);
  endfunction

endpackage

// File: rtl/pe_drain_rr_ptr.sv
// Round-robin bank pointer and per-bank word counter for the drain scheduler.
// Ports:
//   clk, rstn     clock / async active-low reset
//   adv           one read issued this cycle; step to the next bank
//   clr           return both counters to zero (frame end or abort)
//   bank_ptr      bank to read next
//   word_idx      word index within each bank
//   last_issue_c  the next issue is the final word of the frame
module pe_drain_rr_ptr #(
  parameter int unsigned WH     = 2,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned BANK_W = 1,
  parameter int unsigned WORD_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              adv,
  input  logic              clr,
  output logic [BANK_W-1:0] bank_ptr,
  output logic [WORD_W-1:0] word_idx,
  output logic              last_issue_c
);

  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(WH - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(DEPTH - 1);

  logic [BANK_W-1:0] bank_ptr_q, bank_ptr_d;
  logic [WORD_W-1:0] word_idx_q, word_idx_d;

  // Next pointer: banks cycle fastest, word index steps on bank wrap.
  always_comb begin
    bank_ptr_d = bank_ptr_q;
    word_idx_d = word_idx_q;
    if (clr) begin
      bank_ptr_d = '0;
      word_idx_d = '0;
    end else if (adv) begin
      if (bank_ptr_q == BANK_LAST) begin
        bank_ptr_d = '0;
        word_idx_d = (word_idx_q == WORD_LAST) ? '0 : word_idx_q + WORD_W'(1);
      end else begin
        bank_ptr_d = bank_ptr_q + BANK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_ptr_q <= '0;
      word_idx_q <= '0;
    end else begin
      bank_ptr_q <= bank_ptr_d;
      word_idx_q <= word_idx_d;
    end
  end

  assign bank_ptr     = bank_ptr_q;
  assign word_idx     = word_idx_q;
  assign last_issue_c = (bank_ptr_q == BANK_LAST) && (word_idx_q == WORD_LAST);

endmodule

// File: rtl/pe_result_drain_ctrl.sv
// Drains a frame from the Wh result FIFO banks round-robin into one stream
// with a linear destination address, honouring downstream back-pressure.
// Ports:
//   clk, rstn      clock / async active-low reset
//   data_valid     result RAM holds a complete frame
//   row_rom_ready  downstream can accept a word this cycle
//   fifo_dataout   packed bank read data (bank b at b*Iw*DATA_WIDTH)
//   fifo_rden      one-hot bank read enable (combinational)
//   out_data       drained word, valid with out_valid
//   out_valid      out_data/out_bank/out_addr valid
//   out_bank       source bank of out_data
//   out_addr       word_idx*Wh + bank
//   drain_busy     frame drain in progress
//   frame_done     one-cycle pulse after the last word is delivered
//   drain_err      sticky: data_valid lost mid-frame
module pe_result_drain_ctrl
  import pe_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned Iw         = 7,
  parameter int unsigned Wh         = 2,
  parameter int unsigned N          = 256,
  parameter int unsigned HOUT       = 56,
  localparam int unsigned DEPTH      = calc_depth(N, Wh, HOUT, Iw),
  localparam int unsigned BANK_W     = (clog2(Wh) > 0) ? clog2(Wh) : 1,
  localparam int unsigned ADDR_WIDTH = clog2(Wh * DEPTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       data_valid,
  input  logic                       row_rom_ready,
  input  logic [Wh*Iw*DATA_WIDTH-1:0] fifo_dataout,
  output logic [Wh-1:0]              fifo_rden,
  output logic [Iw*DATA_WIDTH-1:0]   out_data,
  output logic                       out_valid,
  output logic [BANK_W-1:0]          out_bank,
  output logic [ADDR_WIDTH-1:0]      out_addr,
  output logic                       drain_busy,
  output logic                       frame_done,
  output logic                       drain_err
);

  localparam int unsigned LANE_W = Iw * DATA_WIDTH;
  localparam int unsigned WORD_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  drain_state_e state_q, state_d;

  logic                  issue_c;
  logic                  clr_c;
  logic [BANK_W-1:0]     bank_ptr;
  logic [WORD_W-1:0]     word_idx;
  logic                  last_issue_c;
  logic [ADDR_WIDTH-1:0] issue_addr_c;

  logic                  pipe_vld_q,  pipe_vld_d;
  logic [BANK_W-1:0]     pipe_bank_q, pipe_bank_d;
  logic [ADDR_WIDTH-1:0] pipe_addr_q, pipe_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q,  err_d;

  logic [LANE_W-1:0]     bank_word [Wh];

  pe_drain_rr_ptr #(
    .WH     (Wh),
    .DEPTH  (DEPTH),
    .BANK_W (BANK_W),
    .WORD_W (WORD_W)
  ) u_rr_ptr (
    .clk          (clk),
    .rstn         (rstn),
    .adv          (issue_c),
    .clr          (clr_c),
    .bank_ptr     (bank_ptr),
    .word_idx     (word_idx),
    .last_issue_c (last_issue_c)
  );

  // Next state, read issue, counter clear and error capture.
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    clr_c   = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (data_valid) state_d = row_rom_ready ? ST_DRAIN : ST_PAUSE;
      end
      ST_DRAIN: begin
        if (!data_valid) begin
          err_d   = 1'b1;
          clr_c   = 1'b1;
          state_d = ST_IDLE;
        end else if (row_rom_ready) begin
          issue_c = 1'b1;
          // The final issue wins over a simultaneous ready drop.
          if (last_issue_c) state_d = ST_FLUSH;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (!data_valid) begin
          err_d   = 1'b1;
          clr_c   = 1'b1;
          state_d = ST_IDLE;
        end else if (row_rom_ready) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE: begin
        clr_c   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-hot read enable at the current bank pointer.
  always_comb begin
    fifo_rden = '0;
    for (int unsigned b = 0; b < Wh; b++) begin
      fifo_rden[b] = issue_c && (bank_ptr == BANK_W'(b));
    end
  end

  assign issue_addr_c = ADDR_WIDTH'(word_idx) * ADDR_WIDTH'(Wh) + ADDR_WIDTH'(bank_ptr);

  // Depth-1 pipe matching the FIFO read latency; status follows next state.
  always_comb begin
    pipe_vld_d  = issue_c;
    pipe_bank_d = issue_c ? bank_ptr : '0;
    pipe_addr_d = issue_c ? issue_addr_c : '0;
    busy_d      = state_d inside {ST_DRAIN, ST_PAUSE, ST_FLUSH};
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pipe_vld_q  <= 1'b0;
      pipe_bank_q <= '0;
      pipe_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_bank_q <= pipe_bank_d;
      pipe_addr_q <= pipe_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // FIFO dout is valid the cycle after rden, so select it with the piped bank.
  for (genvar g = 0; g < Wh; g++) begin : g_bank_word
    assign bank_word[g] = fifo_dataout[g*LANE_W +: LANE_W];
  end

  assign out_data   = pipe_vld_q ? bank_word[pipe_bank_q] : '0;
  assign out_valid  = pipe_vld_q;
  assign out_bank   = pipe_bank_q;
  assign out_addr   = pipe_addr_q;
  assign drain_busy = busy_q;
  assign frame_done = done_q;
  assign drain_err  = err_q;

endmodule

// File: tb/tb_pe_result_drain_ctrl.sv
// Bench for pe_result_drain_ctrl: directed frame scenarios plus random
// data_valid/ready traffic, checked every cycle against a frame-level model.
module tb_pe_result_drain_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned IW    = 7;
  localparam int unsigned WH    = 2;
  localparam int unsigned NCH   = 4;
  localparam int unsigned HO    = 14;
  localparam int unsigned DEPTH = (NCH / WH) * HO / IW;
  localparam int unsigned TOTAL = WH * DEPTH;
  localparam int unsigned LW    = IW * DW;
  localparam int unsigned BW    = 1;
  localparam int unsigned AW    = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_ACT   = 1;
  localparam int PH_FLUSH = 2;
  localparam int PH_DONE  = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             data_valid;
  logic             row_rom_ready;
  logic [WH*LW-1:0] fifo_dataout;
  logic [WH-1:0]    fifo_rden;
  logic [LW-1:0]    out_data;
  logic             out_valid;
  logic [BW-1:0]    out_bank;
  logic [AW-1:0]    out_addr;
  logic             drain_busy;
  logic             frame_done;
  logic             drain_err;

  logic             fifo_clr;
  logic [LW-1:0]    fifo_q   [WH];
  int unsigned      fifo_ptr [WH];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_words;
  int unsigned n_done;

  int          m_phase;
  logic        m_paused;
  int unsigned m_cnt;
  logic        m_err;
  logic        m_pend_vld;
  int unsigned m_pend_addr;

  always #5 clk = ~clk;

  pe_result_drain_ctrl #(
    .DATA_WIDTH (DW),
    .Iw         (IW),
    .Wh         (WH),
    .N          (NCH),
    .HOUT       (HO)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .data_valid    (data_valid),
    .row_rom_ready (row_rom_ready),
    .fifo_dataout  (fifo_dataout),
    .fifo_rden     (fifo_rden),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_bank      (out_bank),
    .out_addr      (out_addr),
    .drain_busy    (drain_busy),
    .frame_done    (frame_done),
    .drain_err     (drain_err)
  );

  // Preloaded bank content: every lane carries bank*16 + word index.
  function automatic logic [LW-1:0] word_of(input int unsigned b, input int unsigned idx);
    logic [LW-1:0] w;
    logic [DW-1:0] v;
    v = DW'(b * 16 + idx);
    for (int l = 0; l < IW; l++) w[l*DW +: DW] = v;
    return w;
  endfunction

  // Result FIFO banks with one-cycle read latency.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < WH; b++) begin
        fifo_q[b]   <= '0;
        fifo_ptr[b] <= 0;
      end
    end else begin
      for (int b = 0; b < WH; b++) begin
        if (fifo_clr) begin
          fifo_ptr[b] <= 0;
        end else if (fifo_rden[b]) begin
          fifo_q[b]   <= word_of(b, fifo_ptr[b]);
          fifo_ptr[b] <= (fifo_ptr[b] + 1) % DEPTH;
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < WH; b++) fifo_dataout[b*LW +: LW] = fifo_q[b];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_phase     = PH_IDLE;
    m_paused    = 1'b0;
    m_cnt       = 0;
    m_err       = 1'b0;
    m_pend_vld  = 1'b0;
    m_pend_addr = 0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic model_check();
    logic [WH-1:0] exp_rden;
    exp_rden = '0;
    if (m_phase == PH_ACT && !m_paused && data_valid && row_rom_ready)
      exp_rden[m_cnt % WH] = 1'b1;
    check_val("rden", 64'(fifo_rden), 64'(exp_rden));
    check_val("out_valid", 64'(out_valid), 64'(m_pend_vld));
    if (m_pend_vld) begin
      check_val("out_addr", 64'(out_addr), 64'(m_pend_addr));
      check_val("out_bank", 64'(out_bank), 64'(m_pend_addr % WH));
      check_val("out_data", 64'(out_data), 64'(word_of(m_pend_addr % WH, m_pend_addr / WH)));
    end
    check_val("drain_busy", 64'(drain_busy), 64'(m_phase == PH_ACT || m_phase == PH_FLUSH));
    check_val("frame_done", 64'(frame_done), 64'(m_phase == PH_DONE));
    check_val("drain_err", 64'(drain_err), 64'(m_err));
    if (out_valid) n_words++;
    if (frame_done) n_done++;

    m_pend_vld  = (exp_rden != '0);
    m_pend_addr = m_cnt;
    case (m_phase)
      PH_IDLE: if (data_valid) begin
        m_phase  = PH_ACT;
        m_paused = !row_rom_ready;
      end
      PH_ACT: begin
        if (!data_valid) begin
          m_err    = 1'b1;
          m_phase  = PH_IDLE;
          m_cnt    = 0;
          fifo_clr = 1'b1;
        end else if (m_paused) begin
          if (row_rom_ready) m_paused = 1'b0;
        end else if (row_rom_ready) begin
          m_cnt++;
          if (m_cnt == TOTAL) m_phase = PH_FLUSH;
        end else begin
          m_paused = 1'b1;
        end
      end
      PH_FLUSH: m_phase = PH_DONE;
      default: begin
        m_phase = PH_IDLE;
        m_cnt   = 0;
      end
    endcase
  endtask

  task automatic step(input logic dv, input logic rdy);
    @(posedge clk);
    #1;
    fifo_clr      = 1'b0;
    data_valid    = dv;
    row_rom_ready = rdy;
    @(negedge clk);
    model_check();
  endtask

  task automatic check_zero_outputs();
    check_val("rst_rden", 64'(fifo_rden), 64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", 64'(out_data), 64'd0);
    check_val("rst_out_bank", 64'(out_bank), 64'd0);
    check_val("rst_out_addr", 64'(out_addr), 64'd0);
    check_val("rst_busy", 64'(drain_busy), 64'd0);
    check_val("rst_done", 64'(frame_done), 64'd0);
    check_val("rst_err", 64'(drain_err), 64'd0);
  endtask

  // Asynchronous reset in the middle of a low clock phase.
  task automatic mid_reset();
    #2;
    rstn          = 1'b0;
    data_valid    = 1'b0;
    row_rom_ready = 1'b0;
    #1;
    check_zero_outputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic clear_counts();
    n_words = 0;
    n_done  = 0;
  endtask

  initial begin
    rstn          = 1'b0;
    data_valid    = 1'b0;
    row_rom_ready = 1'b0;
    fifo_clr      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs();
    @(negedge clk);
    rstn = 1'b1;

    // Full drain with ready held high.
    clear_counts();
    for (int i = 0; i < 14; i++) step(i < 11, 1'b1);
    check_val("full_words", 64'(n_words), 64'(TOTAL));
    check_val("full_done", 64'(n_done), 64'd1);

    // Ready low for 4 cycles after the third issue.
    clear_counts();
    for (int i = 0; i < 18; i++) step(i < 15, !(i >= 4 && i < 8));
    check_val("bp_words", 64'(n_words), 64'(TOTAL));
    check_val("bp_done", 64'(n_done), 64'd1);

    // Ready drops right as the last word is issued.
    clear_counts();
    for (int i = 0; i < 14; i++) step(i < 10, i < 9);
    check_val("lastdrop_words", 64'(n_words), 64'(TOTAL));
    check_val("lastdrop_done", 64'(n_done), 64'd1);

    // data_valid lost after five issues.
    clear_counts();
    for (int i = 0; i < 9; i++) step(i < 6, 1'b1);
    check_val("abort_words", 64'(n_words), 64'd5);
    check_val("abort_done", 64'(n_done), 64'd0);
    check_val("abort_err", 64'(drain_err), 64'd1);

    // Reset while word 3 is on the output, then a clean frame.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check_val("pre_reset_addr", 64'(out_addr), 64'd3);
    mid_reset();
    clear_counts();
    for (int i = 0; i < 14; i++) step(i < 11, 1'b1);
    check_val("post_reset_words", 64'(n_words), 64'(TOTAL));
    check_val("post_reset_done", 64'(n_done), 64'd1);

    // Two frames back to back with data_valid held.
    clear_counts();
    for (int i = 0; i < 24; i++) step(i < 21, 1'b1);
    check_val("b2b_words", 64'(n_words), 64'(2 * TOTAL));
    check_val("b2b_done", 64'(n_done), 64'd2);

    // Random data_valid drops and back-pressure.
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
